// File: rtl/det_matrix_loader.sv
// Loader stage for the determinant engine. It receives one dimension word
// followed by N*N row-major elements, stores them as mem[0]=N and
// mem[i*N+j+1]=a(i,j), holds the engine in reset until the load completes,
// serves the engine's (i, j) reads, and captures its signed result.
module det_matrix_loader #(
  parameter int n       = 20,
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int MAX_DIM = 31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [n-1:0]   in_data,
  output logic           in_ready,
  output logic           det_reset,
  input  logic           read,
  input  logic           write,
  input  logic [n-1:0]   i,
  input  logic [n-1:0]   j,
  output logic [n-1:0]   read_data,
  input  logic [2*n-1:0] write_data,
  input  logic           finish,
  output logic [2*n-1:0] result,
  output logic           result_valid,
  output logic           err
);

  // Wide enough that i*N+j+1 never wraps before the range check.
  localparam int WW = AW + n;

  typedef enum logic [1:0] {
    LOAD_DIM,
    LOAD_ELEM,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [n-1:0]     column_q, column_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             det_reset_q, det_reset_d;
  logic [n-1:0]     read_data_q, read_data_d;
  logic [2*n-1:0]   result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             err_q, err_d;

  logic [n-1:0]     mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  logic             xfer;
  logic             dim_ok;
  logic [WW-1:0]    rd_addr_w;
  logic [WW-1:0]    area_w;
  logic             in_range;
  logic             last_elem;

  assign xfer      = in_valid && in_ready_q;
  assign dim_ok    = (in_data != '0) && (in_data <= n'(MAX_DIM));
  assign rd_addr_w = WW'(i) * WW'(column_q) + WW'(j) + WW'(1);
  assign area_w    = WW'(column_q) * WW'(column_q);
  assign in_range  = (i < column_q) && (j < column_q) && (rd_addr_w < WW'(DEPTH));
  assign last_elem = (WW'(cnt_q) + WW'(1)) == area_w;

  // Next-state and registered-output logic for the load / run / done sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    column_d       = column_q;
    cnt_d          = cnt_q;
    read_data_d    = '0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    mem_we         = 1'b0;
    mem_waddr      = '0;

    if (clear) begin
      // Restart loading; result and RAM contents are intentionally kept.
      state_d        = LOAD_DIM;
      result_valid_d = 1'b0;
      err_d          = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_DIM: begin
          if (xfer) begin
            if (dim_ok) begin
              mem_we    = 1'b1;
              mem_waddr = '0;
              column_d  = in_data;
              cnt_d     = '0;
              state_d   = LOAD_ELEM;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD_ELEM: begin
          if (xfer) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q + AW'(1);
            cnt_d     = cnt_q + AW'(1);
            if (last_elem) begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (read) begin
            if (write) begin
              read_data_d = column_q;
            end else if (in_range) begin
              read_data_d = mem[rd_addr_w[AW-1:0]];
            end else begin
              err_d = 1'b1;
            end
          end
          if (write) begin
            result_d = write_data;
            if (finish) begin
              result_valid_d = 1'b1;
              state_d        = DONE;
            end
          end else if (finish) begin
            err_d = 1'b1;
          end
        end
        DONE: begin
          // Engine inputs are ignored until clear or reset.
        end
        default: state_d = LOAD_DIM;
      endcase
    end

    // Loader accepts words whenever it is about to be in a load state.
    in_ready_d  = (state_d == LOAD_DIM) || (state_d == LOAD_ELEM);
    // Engine reset drops one edge after entering RUN.
    det_reset_d = clear || (state_q == LOAD_DIM) || (state_q == LOAD_ELEM);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q        <= LOAD_DIM;
      column_q       <= '0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b0;
      det_reset_q    <= 1'b1;
      read_data_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      column_q       <= column_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      det_reset_q    <= det_reset_d;
      read_data_q    <= read_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
    end
  end

  // Matrix RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; it is always fully rewritten by a load before it is read.
    if (mem_we) begin
      mem[mem_waddr] <= in_data;
    end
  end

  assign in_ready     = in_ready_q;
  assign det_reset    = det_reset_q;
  assign read_data    = read_data_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_det_matrix_loader.sv
// Self-checking bench for det_matrix_loader: a matrix-level reference model
// predicts every output each cycle, and directed steps pin literal values.
module tb_det_matrix_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [19:0] in_data;
  logic        in_ready;
  logic        det_reset;
  logic        read;
  logic        write;
  logic [19:0] i;
  logic [19:0] j;
  logic [19:0] read_data;
  logic [39:0] write_data;
  logic        finish;
  logic [39:0] result;
  logic        result_valid;
  logic        err;

  int n_vec      = 0;
  int n_miscmp   = 0;
  bit chk_en     = 1'b0;

  det_matrix_loader dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .det_reset    (det_reset),
    .read         (read),
    .write        (write),
    .i            (i),
    .j            (j),
    .read_data    (read_data),
    .write_data   (write_data),
    .finish       (finish),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (matrix level) ----------------
  logic [19:0] mat [31][31];
  int          m_dim;      // 0 while waiting for a dimension word
  int          m_got;      // elements received so far
  bit          m_running;  // full matrix held, engine working
  bit          m_done;     // result captured
  logic        exp_in_ready, exp_det_reset, exp_result_valid, exp_err;
  logic [19:0] exp_read_data;
  logic [39:0] exp_result;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_dim = 0; m_got = 0; m_running = 0; m_done = 0;
      exp_in_ready = 0; exp_det_reset = 1; exp_read_data = 0;
      exp_result = 0; exp_result_valid = 0; exp_err = 0;
    end else begin
      bit was_running, was_done, accepted;
      was_running   = m_running;
      was_done      = m_done;
      accepted      = in_valid && exp_in_ready;
      exp_read_data = 0;
      if (clear) begin
        m_dim = 0; m_got = 0; m_running = 0; m_done = 0;
        exp_result_valid = 0; exp_err = 0;
        exp_det_reset = 1; exp_in_ready = 1;
      end else begin
        if (accepted) begin
          if (m_dim == 0) begin
            if (in_data >= 1 && in_data <= 31) m_dim = int'(in_data);
            else exp_err = 1;
          end else begin
            mat[m_got / m_dim][m_got % m_dim] = in_data;
            m_got++;
            if (m_got == m_dim * m_dim) m_running = 1;
          end
        end
        if (was_running) begin
          if (read) begin
            if (write) exp_read_data = 20'(m_dim);
            else if (i < m_dim && j < m_dim) exp_read_data = mat[i][j];
            else exp_err = 1;
          end
          if (write) begin
            exp_result = write_data;
            if (finish) begin
              exp_result_valid = 1; m_done = 1; m_running = 0;
            end
          end else if (finish) begin
            exp_err = 1;
          end
        end
        exp_det_reset = !(was_running || was_done);
        exp_in_ready  = !(m_running || m_done);
      end
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",     in_ready,     exp_in_ready);
      check("det_reset",    det_reset,    exp_det_reset);
      check("read_data",    read_data,    exp_read_data);
      check("result",       result,       exp_result);
      check("result_valid", result_valid, exp_result_valid);
      check("err",          err,          exp_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear = 0; in_valid = 0; in_data = 0; read = 0; write = 0;
    i = 0; j = 0; write_data = 0; finish = 0;
  endtask

  task automatic send(input int w);
    in_valid = 1; in_data = 20'(w);
    tick();
    in_valid = 0;
  endtask

  task automatic rd(input int ii, input int jj);
    read = 1; i = 20'(ii); j = 20'(jj);
    tick();
    read = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    chk_en = 1;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1'b1);

    // 2x2 load: 3 1 / 4 2
    send(2); send(3); send(1); send(4); send(2);
    check("in_ready_drop", in_ready, 1'b0);
    check("det_reset_still_high", det_reset, 1'b1);
    tick();
    check("det_reset_low", det_reset, 1'b0);
    rd(1, 0);
    check("read_1_0", read_data, 20'd4);
    write = 1; write_data = 5;
    rd(0, 0);
    write = 0;
    check("read_write_dim", read_data, 20'd2);

    // Final result -2, sign-extended
    write = 1; finish = 1; write_data = -2;
    tick();
    write = 0; finish = 0;
    check("result_neg2", result, 40'hFF_FFFF_FFFE);
    check("result_valid_set", result_valid, 1'b1);
    rd(0, 0);
    check("read_in_done", read_data, 20'd0);

    // Invalid dimensions then a 1x1 load
    do_clear();
    send(0);
    check("err_dim0", err, 1'b1);
    send(32);
    check("in_ready_after_bad_dims", in_ready, 1'b1);
    send(1); send(7);
    tick();
    rd(0, 0);
    check("read_1x1", read_data, 20'd7);
    check("err_sticky", err, 1'b1);

    // 3x3 load with out-of-range reads
    do_clear();
    send(3);
    for (int k = 0; k < 9; k++) send(11 + k);
    tick();
    rd(3, 0);
    check("oob_read_data", read_data, 20'd0);
    check("oob_err", err, 1'b1);
    rd(2, 2);
    check("read_2_2", read_data, 20'd19);
    rd(20'h400, 0);
    check("wide_idx_read", read_data, 20'd0);

    // Clear in the middle of an element stream
    do_clear();
    send(2); send(10); send(11);
    clear = 1; in_valid = 1; in_data = 12;
    tick();
    clear = 0; in_valid = 0;
    check("clear_in_ready", in_ready, 1'b1);
    check("clear_det_reset", det_reset, 1'b1);
    send(2); send(5); send(6); send(7); send(8);
    tick();
    rd(0, 1);
    check("reload_read_0_1", read_data, 20'd6);

    // Asynchronous reset in RUN with a read active
    read = 1; i = 0; j = 0;
    tick();
    #2 reset = 0;
    #1;
    check("rst_read_data", read_data, 20'd0);
    check("rst_det_reset", det_reset, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1; read = 0;
    #1 check("in_ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1'b1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      clear    = ($urandom_range(0, 99) < (m_done ? 20 : 1));
      in_valid = ($urandom_range(0, 99) < 70);
      if (m_dim == 0)
        in_data = ($urandom_range(0, 9) < 8) ? 20'($urandom_range(1, 5))
                                             : 20'($urandom_range(0, 1) ? 0 : $urandom_range(32, 1 << 19));
      else
        in_data = 20'($urandom);
      read = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 9))
        0:       begin i = 20'hFFFFF; j = 20'($urandom_range(0, m_dim)); end
        1:       begin i = 20'($urandom_range(0, m_dim)); j = 20'h400; end
        default: begin i = 20'($urandom_range(0, m_dim)); j = 20'($urandom_range(0, m_dim)); end
      endcase
      write      = ($urandom_range(0, 99) < 10);
      finish     = ($urandom_range(0, 99) < 5);
      write_data = {20'($urandom), 20'($urandom)};
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
